// File: rtl/fpu_ss_lsu.sv
// FPU subsystem load/store unit: one outstanding FLW/FSW/FLH/FSH at a time.
// Optional half-precision memory access is enabled with macro FPU_SS_LSU_ZFH_EN.
package fpu_ss_pkg;
  typedef enum logic {
    Word     = 1'b0,
    HalfWord = 1'b1
  } ls_size_e;
endpackage

module fpu_ss_lsu #(
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_load_i,
  input  logic                  req_is_store_i,
  input  logic [3:0]            req_be_i,
  input  fpu_ss_pkg::ls_size_e  req_size_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [4:0]            req_rd_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  output logic [ID_WIDTH-1:0]   mem_id_o,
  input  logic                  mem_result_valid_i,
  input  logic [31:0]           mem_result_rdata_i,
  input  logic                  mem_result_err_i,
  input  logic [ID_WIDTH-1:0]   mem_result_id_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic [ID_WIDTH-1:0]   wb_id_o,
  output logic                  store_done_o,
  output logic                  err_o,
  output logic [ID_WIDTH-1:0]   err_id_o,
  output logic                  busy_o
);
  import fpu_ss_pkg::*;

`ifdef FPU_SS_LSU_ZFH_EN
  localparam bit ZfhEn = 1'b1;
`else
  localparam bit ZfhEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

  state_e              state_reg;
  logic                load_reg;
  logic [3:0]          be_reg;
  ls_size_e            size_reg;
  logic [4:0]          rd_reg;
  logic [ID_WIDTH-1:0] id_reg;

  logic                mem_valid_reg, mem_we_reg;
  logic [31:0]         mem_addr_reg, mem_wdata_reg;
  logic [3:0]          mem_be_reg;
  logic [ID_WIDTH-1:0] mem_id_reg;
  logic                wb_valid_reg;
  logic [4:0]          wb_rd_reg;
  logic [31:0]         wb_data_reg;
  logic [ID_WIDTH-1:0] wb_id_reg;
  logic                store_done_reg, err_reg;
  logic [ID_WIDTH-1:0] err_id_reg;

  logic        hw_reject;
  logic        result_hit;
  logic [31:0] ld_data;

  // Without half-precision support a HalfWord request is rejected at accept.
  assign hw_reject  = !ZfhEn && (req_size_i == HalfWord);
  assign result_hit = mem_result_valid_i && (mem_result_id_i == id_reg);

  // Half-word loads select the lane named by the byte enable and NaN-box it.
  always_comb begin
    ld_data = mem_result_rdata_i;
    if (size_reg == HalfWord) begin
      if (be_reg[3:2] == 2'b11) ld_data = {16'hFFFF, mem_result_rdata_i[31:16]};
      else                      ld_data = {16'hFFFF, mem_result_rdata_i[15:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      load_reg       <= 1'b0;
      be_reg         <= '0;
      size_reg       <= Word;
      rd_reg         <= '0;
      id_reg         <= '0;
      mem_valid_reg  <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_be_reg     <= '0;
      mem_id_reg     <= '0;
      wb_valid_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      wb_id_reg      <= '0;
      store_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      err_id_reg     <= '0;
    end else begin
      store_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid_i && (req_is_load_i || req_is_store_i)) begin
            load_reg <= req_is_load_i;
            be_reg   <= req_be_i;
            size_reg <= req_size_i;
            rd_reg   <= req_rd_i;
            id_reg   <= req_id_i;
            if (hw_reject) begin
              err_reg    <= 1'b1;
              err_id_reg <= req_id_i;
            end else begin
              mem_valid_reg <= 1'b1;
              mem_addr_reg  <= req_addr_i;
              mem_we_reg    <= !req_is_load_i;
              mem_be_reg    <= req_be_i;
              mem_id_reg    <= req_id_i;
              mem_wdata_reg <= (req_size_i == HalfWord) ?
                               {req_wdata_i[15:0], req_wdata_i[15:0]} : req_wdata_i;
              state_reg     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            mem_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (result_hit) begin
            if (mem_result_err_i) begin
              err_reg    <= 1'b1;
              err_id_reg <= id_reg;
              state_reg  <= IDLE;
            end else if (!load_reg) begin
              store_done_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              wb_valid_reg <= 1'b1;
              wb_rd_reg    <= rd_reg;
              wb_id_reg    <= id_reg;
              wb_data_reg  <= ld_data;
              state_reg    <= WB;
            end
          end
        end
        WB: begin
          if (wb_ready_i) begin
            wb_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_reg == IDLE);
  assign busy_o       = (state_reg != IDLE);
  assign mem_valid_o  = mem_valid_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_we_o     = mem_we_reg;
  assign mem_be_o     = mem_be_reg;
  assign mem_wdata_o  = mem_wdata_reg;
  assign mem_id_o     = mem_id_reg;
  assign wb_valid_o   = wb_valid_reg;
  assign wb_rd_o      = wb_rd_reg;
  assign wb_data_o    = wb_data_reg;
  assign wb_id_o      = wb_id_reg;
  assign store_done_o = store_done_reg;
  assign err_o        = err_reg;
  assign err_id_o     = err_id_reg;
endmodule

// File: tb/tb_fpu_ss_lsu.sv
// Directed bench for fpu_ss_lsu; half-word cases follow FPU_SS_LSU_ZFH_EN.
module tb_fpu_ss_lsu;
  import fpu_ss_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_is_load_i, req_is_store_i;
  logic [3:0]  req_be_i;
  ls_size_e    req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic [3:0]  req_id_i;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o, mem_id_o;
  logic        mem_result_valid_i, mem_result_err_i;
  logic [31:0] mem_result_rdata_i;
  logic [3:0]  mem_result_id_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_id_o;
  logic        store_done_o, err_o, busy_o;
  logic [3:0]  err_id_o;

  int n_cmp = 0;
  int n_err = 0;
  int mem_hs = 0;
  int wb_hs = 0;

  fpu_ss_lsu #(.ID_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_load_i(req_is_load_i), .req_is_store_i(req_is_store_i),
    .req_be_i(req_be_i), .req_size_i(req_size_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .req_id_i(req_id_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_id_o(mem_id_o), .mem_result_valid_i(mem_result_valid_i),
    .mem_result_rdata_i(mem_result_rdata_i), .mem_result_err_i(mem_result_err_i),
    .mem_result_id_i(mem_result_id_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_id_o(wb_id_o),
    .store_done_o(store_done_o), .err_o(err_o), .err_id_o(err_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_valid_o && mem_ready_i) mem_hs <= mem_hs + 1;
    if (wb_valid_o && wb_ready_i)   wb_hs  <= wb_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one request for exactly one cycle; returns 1 ns into cycle T+1.
  task automatic issue(input logic ld, input logic st, input logic [3:0] be,
                       input ls_size_e sz, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [3:0] id);
    req_is_load_i  = ld;
    req_is_store_i = st;
    req_be_i       = be;
    req_size_i     = sz;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_rd_i       = rd;
    req_id_i       = id;
    req_valid_i    = 1'b1;
    step();
    req_valid_i    = 1'b0;
  endtask

  task automatic result(input logic [3:0] id, input logic [31:0] rdata, input logic err);
    mem_result_valid_i = 1'b1;
    mem_result_id_i    = id;
    mem_result_rdata_i = rdata;
    mem_result_err_i   = err;
    step();
    mem_result_valid_i = 1'b0;
    mem_result_err_i   = 1'b0;
  endtask

  initial begin
    int mem_hs0, wb_hs0;
    rst_ni = 1'b0;
    req_valid_i = 0; req_is_load_i = 0; req_is_store_i = 0; req_be_i = 0;
    req_size_i = Word; req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0; req_id_i = 0;
    mem_ready_i = 1; mem_result_valid_i = 0; mem_result_rdata_i = 0;
    mem_result_err_i = 0; mem_result_id_i = 0; wb_ready_i = 1;
    step(); step();
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_wb_valid",  32'(wb_valid_o), 32'd0);
    chk("rst_busy",      32'(busy_o), 32'd0);
    chk("rst_pulses",    32'({err_o, store_done_o}), 32'd0);
    chk("rst_mem_addr",  mem_addr_o, 32'd0);
    rst_ni = 1'b1;
    step();

    // FLW with no backpressure
    issue(1, 0, 4'hF, Word, 32'h100, 32'h0, 5'd3, 4'd5);
    chk("flw_mem_valid", 32'(mem_valid_o), 32'd1);
    chk("flw_mem_addr",  mem_addr_o, 32'h100);
    chk("flw_mem_be",    32'(mem_be_o), 32'hF);
    chk("flw_mem_we",    32'(mem_we_o), 32'd0);
    chk("flw_mem_id",    32'(mem_id_o), 32'd5);
    chk("flw_req_ready", 32'(req_ready_o), 32'd0);
    step();
    chk("flw_mem_drop",  32'(mem_valid_o), 32'd0);
    result(4'd5, 32'h3F800000, 1'b0);
    chk("flw_wb_valid",  32'(wb_valid_o), 32'd1);
    chk("flw_wb_data",   wb_data_o, 32'h3F800000);
    chk("flw_wb_rd",     32'(wb_rd_o), 32'd3);
    chk("flw_wb_id",     32'(wb_id_o), 32'd5);
    step();
    chk("flw_wb_done",   32'(wb_valid_o), 32'd0);
    chk("flw_ready_t4",  32'(req_ready_o), 32'd1);

    // FSW word store
    issue(0, 1, 4'hF, Word, 32'h200, 32'hDEADBEEF, 5'd0, 4'd9);
    chk("fsw_mem_we",    32'(mem_we_o), 32'd1);
    chk("fsw_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    step();
    result(4'd9, 32'h0, 1'b0);
    chk("fsw_done",      32'(store_done_o), 32'd1);
    chk("fsw_idle",      32'(busy_o), 32'd0);
    chk("fsw_no_wb",     32'(wb_valid_o), 32'd0);
    step();
    chk("fsw_done_pulse", 32'(store_done_o), 32'd0);

`ifdef FPU_SS_LSU_ZFH_EN
    issue(0, 1, 4'hC, HalfWord, 32'h202, 32'h0000ABCD, 5'd0, 4'd4);
    chk("fsh_mem_wdata", mem_wdata_o, 32'hABCDABCD);
    chk("fsh_mem_be",    32'(mem_be_o), 32'hC);
    chk("fsh_mem_we",    32'(mem_we_o), 32'd1);
    step();
    result(4'd4, 32'h0, 1'b0);
    chk("fsh_done",      32'(store_done_o), 32'd1);
    step();
    chk("fsh_done_pulse", 32'(store_done_o), 32'd0);

    issue(1, 0, 4'hC, HalfWord, 32'h302, 32'h0, 5'd8, 4'd6);
    step();
    result(4'd6, 32'h12345678, 1'b0);
    chk("flh_hi_data",   wb_data_o, 32'hFFFF1234);
    step();
    issue(1, 0, 4'h3, HalfWord, 32'h300, 32'h0, 5'd9, 4'd6);
    step();
    result(4'd6, 32'h12345678, 1'b0);
    chk("flh_lo_data",   wb_data_o, 32'hFFFF5678);
    step();
`else
    mem_hs0 = mem_hs;
    issue(1, 0, 4'h3, HalfWord, 32'h300, 32'h0, 5'd9, 4'd6);
    chk("hw_rej_err",    32'(err_o), 32'd1);
    chk("hw_rej_err_id", 32'(err_id_o), 32'd6);
    chk("hw_rej_no_mem", 32'(mem_valid_o), 32'd0);
    chk("hw_rej_idle",   32'(busy_o), 32'd0);
    step();
    chk("hw_rej_pulse",  32'(err_o), 32'd0);
    chk("hw_rej_mem_hs", 32'(mem_hs - mem_hs0), 32'd0);
`endif

    // Both flags set behaves as a load; neither flag drops the request
    issue(1, 1, 4'hF, Word, 32'h180, 32'h0, 5'd2, 4'd3);
    chk("both_is_load",  32'(mem_we_o), 32'd0);
    step();
    result(4'd3, 32'h40000000, 1'b0);
    chk("both_wb_valid", 32'(wb_valid_o), 32'd1);
    step();
    issue(0, 0, 4'hF, Word, 32'h190, 32'h0, 5'd2, 4'd3);
    chk("none_dropped",  32'(busy_o), 32'd0);
    chk("none_no_mem",   32'(mem_valid_o), 32'd0);

    // Backpressure on both channels
    mem_hs0 = mem_hs;
    wb_hs0  = wb_hs;
    mem_ready_i = 0;
    wb_ready_i  = 0;
    issue(1, 0, 4'hF, Word, 32'h300, 32'h0, 5'd7, 4'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_mem_valid_%0d", i), 32'(mem_valid_o), 32'd1);
      chk($sformatf("bp_mem_addr_%0d", i),  mem_addr_o, 32'h300);
      chk($sformatf("bp_req_ready_%0d", i), 32'(req_ready_o), 32'd0);
      if (i == 2) mem_ready_i = 1;
      step();
    end
    chk("bp_mem_released", 32'(mem_valid_o), 32'd0);
    result(4'd1, 32'hC0490FDB, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("bp_wb_valid_%0d", i),  32'(wb_valid_o), 32'd1);
      chk($sformatf("bp_wb_data_%0d", i),   wb_data_o, 32'hC0490FDB);
      chk($sformatf("bp_wb_rd_%0d", i),     32'(wb_rd_o), 32'd7);
      chk($sformatf("bp_req_ready_w%0d", i), 32'(req_ready_o), 32'd0);
      step();
    end
    wb_ready_i = 1;
    step();
    chk("bp_wb_done",    32'(wb_valid_o), 32'd0);
    chk("bp_back_idle",  32'(req_ready_o), 32'd1);
    chk("bp_mem_hs",     32'(mem_hs - mem_hs0), 32'd1);
    chk("bp_wb_hs",      32'(wb_hs - wb_hs0), 32'd1);

    // Stray ID then error result
    issue(1, 0, 4'hF, Word, 32'h400, 32'h0, 5'd4, 4'd7);
    step();
    result(4'd2, 32'h11111111, 1'b0);
    chk("stray_no_wb",   32'(wb_valid_o), 32'd0);
    chk("stray_busy",    32'(busy_o), 32'd1);
    chk("stray_no_err",  32'(err_o), 32'd0);
    result(4'd7, 32'h0, 1'b1);
    chk("err_pulse",     32'(err_o), 32'd1);
    chk("err_id",        32'(err_id_o), 32'd7);
    chk("err_no_wb",     32'(wb_valid_o), 32'd0);
    chk("err_idle",      32'(busy_o), 32'd0);
    step();
    chk("err_pulse_end", 32'(err_o), 32'd0);

    // Reset while waiting for a store result
    issue(0, 1, 4'hF, Word, 32'h500, 32'h55AA55AA, 5'd0, 4'd10);
    step();
    chk("rw_in_wait",    32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rw_req_ready",  32'(req_ready_o), 32'd1);
    chk("rw_busy",       32'(busy_o), 32'd0);
    chk("rw_mem_id",     32'(mem_id_o), 32'd0);
    chk("rw_mem_wdata",  mem_wdata_o, 32'd0);
    step();
    rst_ni = 1'b1;
    step();
    result(4'd10, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rw_quiet_%0d", i), 32'({store_done_o, err_o, wb_valid_o}), 32'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
